// File: rtl/ili9341_parallel_8bit_rx.sv
// Receiver for the ILI9341 8080-style 8-bit write bus. It synchronises the pins,
// decodes commands and parameters, and turns RAMWR data into (x, y, r, g, b)
// pixels that walk the current CASET/PASET window.
module ili9341_parallel_8bit_rx #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rst_n,
  input  logic       lcd_cs_n,
  input  logic       lcd_rs,
  input  logic       lcd_wr_n,
  input  logic       lcd_rd_n,
  input  logic [7:0] lcd_d,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       pix_valid,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    CTX_IDLE, CTX_CASET, CTX_PASET, CTX_COLMOD, CTX_RAMWR, CTX_OTHER
  } ctx_e;

  localparam logic [15:0] W_LIM      = 16'(WIDTH);
  localparam logic [15:0] H_LIM      = 16'(HEIGHT);
  localparam logic [15:0] EC_RST     = 16'(WIDTH - 1);
  localparam logic [15:0] EP_RST     = 16'(HEIGHT - 1);
  localparam logic [7:0]  COLMOD_RST = 8'h66;
  // Bus bundle {rst_n, cs_n, rs, wr_n, d[7:0]}; idle = deasserted strobes.
  localparam logic [11:0] BUS_IDLE   = 12'hD00;

  // Reads are not supported; the strobe is accepted and deliberately ignored.
  logic unused_rd;
  assign unused_rd = lcd_rd_n;

  logic [SYNC_STAGES-1:0][11:0] bus_sync_q;
  logic        wr_prev_q, cs_prev_q;
  logic [11:0] bus_s;
  logic        rst_n_s, cs_n_s, rs_s, wr_n_s;
  logic [7:0]  d_s;
  logic        byte_ev, cs_rise, is_cmd, is_data;

  ctx_e        ctx_q;
  logic        cmd_valid_q, pix_valid_q, frame_done_q;
  logic [7:0]  cmd_code_q, pix_r_q, pix_g_q, pix_b_q;
  logic [8:0]  pix_x_q, pix_y_q;
  logic [15:0] sc_q, ec_q, sp_q, ep_q, cur_x_q, cur_y_q;
  logic [7:0]  colmod_q, b0_q, b1_q;
  logic [23:0] par_q;
  logic [2:0]  pidx_q;
  logic [1:0]  phase_q;

  logic        mode16, pix_done, in_range, last_d, soft_rst, swrst;
  logic [7:0]  pix_r_d, pix_g_d, pix_b_d;
  logic [15:0] nx_x_d, nx_y_d;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;

  assign bus_s   = bus_sync_q[SYNC_STAGES-1];
  assign rst_n_s = bus_s[11];
  assign cs_n_s  = bus_s[10];
  assign rs_s    = bus_s[9];
  assign wr_n_s  = bus_s[8];
  assign d_s     = bus_s[7:0];
  // D and RS come from the same stage as WR, so they line up with the edge.
  assign byte_ev = wr_n_s & ~wr_prev_q & ~cs_n_s;
  assign cs_rise = cs_n_s & ~cs_prev_q;
  assign is_cmd  = byte_ev & ~rs_s;
  assign is_data = byte_ev & rs_s;

  assign r5 = b0_q[7:3];
  assign g6 = {b0_q[2:0], d_s[7:5]};
  assign b5 = d_s[4:0];

  // Synchroniser chain on every bus pin plus edge-detect history of WR and CS.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every flop samples the pre-edge values.
    if (reset) begin
      bus_sync_q <= {SYNC_STAGES{BUS_IDLE}};
      wr_prev_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
    end else begin
      bus_sync_q <= {bus_sync_q[SYNC_STAGES-2:0],
                     {lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_d}};
      wr_prev_q  <= wr_n_s;
      cs_prev_q  <= cs_n_s;
    end
  end

  // Pixel colour expansion, pixel-complete detect and window cursor advance.
  always_comb begin
    // NOTE: every output gets a value before any branch, so no latch is inferred.
    mode16  = (colmod_q == 8'h55);
    pix_r_d = {b0_q[7:2], b0_q[7:6]};
    pix_g_d = {b1_q[7:2], b1_q[7:6]};
    pix_b_d = {d_s[7:2], d_s[7:6]};
    if (mode16) begin
      pix_r_d = {r5, r5[4:2]};
      pix_g_d = {g6, g6[5:4]};
      pix_b_d = {b5, b5[4:2]};
    end
    pix_done = is_data && (ctx_q == CTX_RAMWR) &&
               (phase_q == (mode16 ? 2'd1 : 2'd2));
    in_range = (cur_x_q < W_LIM) && (cur_y_q < H_LIM);
    nx_x_d   = cur_x_q + 16'd1;
    nx_y_d   = cur_y_q;
    last_d   = 1'b0;
    if (cur_x_q == ec_q) begin
      nx_x_d = sc_q;
      if (cur_y_q == ep_q) begin
        nx_y_d = sp_q;
        last_d = 1'b1;
      end else begin
        nx_y_d = cur_y_q + 16'd1;
      end
    end
    swrst    = is_cmd && (d_s == 8'h01) && !reset && rst_n_s;
    soft_rst = reset || !rst_n_s || swrst;
  end

  // Context FSM, parameter capture, pixel assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      ctx_q        <= CTX_IDLE;
      cmd_valid_q  <= swrst;
      cmd_code_q   <= swrst ? 8'h01 : 8'h00;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      sc_q         <= '0;
      ec_q         <= EC_RST;
      sp_q         <= '0;
      ep_q         <= EP_RST;
      colmod_q     <= COLMOD_RST;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      par_q        <= '0;
      pidx_q       <= '0;
      phase_q      <= '0;
    end else begin
      cmd_valid_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (is_cmd) begin
        cmd_valid_q <= 1'b1;
        cmd_code_q  <= d_s;
        pidx_q      <= '0;
        phase_q     <= '0;
        case (d_s)
          8'h2A:   ctx_q <= CTX_CASET;
          8'h2B:   ctx_q <= CTX_PASET;
          8'h3A:   ctx_q <= CTX_COLMOD;
          8'h2C: begin
            ctx_q   <= CTX_RAMWR;
            cur_x_q <= sc_q;
            cur_y_q <= sp_q;
          end
          8'h3C:   ctx_q <= CTX_RAMWR;
          default: ctx_q <= CTX_OTHER;
        endcase
      end else if (is_data) begin
        case (ctx_q)
          CTX_CASET, CTX_PASET: begin
            if (pidx_q != 3'd4) pidx_q <= pidx_q + 3'd1;
            case (pidx_q)
              3'd0: par_q[23:16] <= d_s;
              3'd1: par_q[15:8]  <= d_s;
              3'd2: par_q[7:0]   <= d_s;
              3'd3: begin
                // Start and end commit together on the fourth byte only.
                if (ctx_q == CTX_CASET) begin
                  sc_q <= par_q[23:8];
                  ec_q <= {par_q[7:0], d_s};
                end else begin
                  sp_q <= par_q[23:8];
                  ep_q <= {par_q[7:0], d_s};
                end
              end
              default: ;
            endcase
          end
          CTX_COLMOD: begin
            if (pidx_q == 3'd0) colmod_q <= d_s;
            if (pidx_q != 3'd4) pidx_q <= pidx_q + 3'd1;
          end
          CTX_RAMWR: begin
            if (pix_done) begin
              phase_q      <= '0;
              pix_x_q      <= cur_x_q[8:0];
              pix_y_q      <= cur_y_q[8:0];
              pix_r_q      <= pix_r_d;
              pix_g_q      <= pix_g_d;
              pix_b_q      <= pix_b_d;
              pix_valid_q  <= in_range;
              frame_done_q <= last_d;
              cur_x_q      <= nx_x_d;
              cur_y_q      <= nx_y_d;
            end else begin
              phase_q <= phase_q + 2'd1;
              if (phase_q == 2'd0) b0_q <= d_s;
              else                 b1_q <= d_s;
            end
          end
          default: ;
        endcase
      end
      // Deselecting the chip abandons any partially received pixel.
      if (cs_rise) phase_q <= '0;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_r      = pix_r_q;
  assign pix_g      = pix_g_q;
  assign pix_b      = pix_b_q;
  assign frame_done = frame_done_q;

endmodule
